// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: word width and loader FSM states.
package imem_loader_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [2:0] {
    LD_LEN_LO = 3'd0,
    LD_LEN_HI = 3'd1,
    LD_DATA   = 3'd2,
    LD_CHECK  = 3'd3,
    LD_FINISH = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERROR  = 3'd6
  } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes MSB-first into WIDTH-bit words; flags the 4th byte of each word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic             word_complete
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {word[WIDTH-9:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Combinational so the write strobe can be registered exactly one cycle after the 4th accept.
  assign word_complete = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> word writes, holds CPU until complete.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  ld_state_t       state, state_n;
  logic [7:0]      len_lo;
  logic [15:0]     hdr;
  logic [ADDR_W:0] len_words;
  logic [ADDR_W:0] word_idx;
  logic            accept;
  logic            word_complete;
  logic            last_word;
  logic [WIDTH-1:0] packed_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  localparam ld_state_t AFTER_DATA = LD_CHECK;
`else
  localparam ld_state_t AFTER_DATA = LD_FINISH;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LD_LEN_LO, LD_LEN_HI, LD_DATA: in_ready = !reload;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK:                      in_ready = !reload;
`endif
      default:                       in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign hdr       = {in_data, len_lo};
  assign last_word = (word_idx == (len_words - IDX_ONE));

  byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (reload),
    .shift_en      (accept && (state == LD_DATA)),
    .byte_in       (in_data),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_n = state;
    case (state)
      LD_LEN_LO: if (accept) state_n = LD_LEN_HI;
      LD_LEN_HI: begin
        if (accept) begin
          if (hdr == 16'd0)             state_n = AFTER_DATA;
          else if (hdr > 16'(DEPTH))    state_n = LD_ERROR;
          else                          state_n = LD_DATA;
        end
      end
      LD_DATA:   if (word_complete && last_word) state_n = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK:  if (accept) state_n = (in_data == csum) ? LD_FINISH : LD_ERROR;
`endif
      LD_FINISH: state_n = LD_DONE;
      LD_DONE:   state_n = LD_DONE;
      LD_ERROR:  state_n = LD_ERROR;
      default:   state_n = LD_LEN_LO;
    endcase
    if (reload) state_n = LD_LEN_LO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LD_LEN_LO;
      len_lo    <= '0;
      len_words <= '0;
      word_idx  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state <= state_n;
      // A strobe scheduled by the previous cycle's 4th byte still issues under reload.
      wr_en <= word_complete;
      if (accept && (state == LD_LEN_LO)) len_lo <= in_data;
      if (reload) begin
        word_idx <= '0;
      end else if (accept && (state == LD_LEN_HI)) begin
        len_words <= hdr[ADDR_W:0];
        word_idx  <= '0;
      end else if (word_complete) begin
        wr_addr  <= word_idx[ADDR_W-1:0];
        word_idx <= word_idx + IDX_ONE;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || reload) csum <= '0;
    else if (accept)     csum <= csum ^ in_data;
  end
`endif

  assign wr_data  = packed_word;
  assign cpu_hold = (state != LD_DONE);
  assign done     = (state == LD_DONE);
  assign error    = (state == LD_ERROR);

endmodule
